// File: rtl/pxs_ball_motion_ctrl.sv
// Per-frame ball motion controller: one position step per end-of-frame, with border
// bounces, edge-triggered speed requests and pause. Stream layout: {XC[9:0], YC[9:0], RGB[5:0]}.
module pxs_ball_motion_ctrl #(
    parameter int SIZE_BALL   = 16,
    parameter int VISIBLECOLS = 640,
    parameter int VISIBLEROWS = 480,
    parameter int SPEED_INIT  = 1,
    parameter int SPEED_MAX   = 20,
    parameter int X_INIT      = 156,
    parameter int Y_INIT      = 232
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic [25:0] RGBStr_i,
    input  logic        inc_vel,
    input  logic        dec_vel,
    input  logic        pause,
    output logic [9:0]  x_ball,
    output logic [9:0]  y_ball,
    output logic [4:0]  speed,
    output logic        dx,
    output logic        dy,
    output logic        bounce_x,
    output logic        bounce_y,
    output logic        upd_done
);

    localparam logic [10:0] XMAX  = 11'(VISIBLECOLS - SIZE_BALL);
    localparam logic [10:0] YMAX  = 11'(VISIBLEROWS - SIZE_BALL);
    localparam logic [9:0]  XLAST = 10'(VISIBLECOLS - 1);
    localparam logic [9:0]  YLAST = 10'(VISIBLEROWS - 1);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [4:0]  speed_q, speed_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic        bx_q, bx_d, by_q, by_d, upd_q, upd_d;
    logic        pend_inc_q, pend_inc_d, pend_dec_q, pend_dec_d;
    logic        eof_raw_q, eof_prev_q, inc_q, dec_q;
    logic        eof_raw, eof, inc_edge, dec_edge;
    logic [11:0] xs, ys;

    // Returns {bounce, new_dir, new_pos}; 11-bit sum keeps pos+speed from wrapping.
    function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic dir,
                                              input logic [4:0] spd, input logic [10:0] maxp);
        logic [10:0] sum;
        sum = {1'b0, pos} + {6'b0, spd};
        axis_step = {1'b0, dir, pos};
        if (spd != 5'd0) begin
            if (!dir) begin
                if (sum >= maxp) axis_step = {1'b1, 1'b1, maxp[9:0]};
                else             axis_step = {1'b0, 1'b0, sum[9:0]};
            end else begin
                if ({1'b0, pos} <= {6'b0, spd}) axis_step = {1'b1, 1'b0, 10'd0};
                else                            axis_step = {1'b0, 1'b1, pos - {5'b0, spd}};
            end
        end
    endfunction

    assign eof_raw  = (RGBStr_i[25:16] == XLAST) && (RGBStr_i[15:6] == YLAST);
    assign eof      = eof_raw_q & ~eof_prev_q;
    assign inc_edge = inc_vel & ~inc_q;
    assign dec_edge = dec_vel & ~dec_q;

    assign xs = axis_step(x_q, dx_q, speed_q, XMAX);
    assign ys = axis_step(y_q, dy_q, speed_q, YMAX);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        speed_d    = speed_q;
        bx_d       = 1'b0;
        by_d       = 1'b0;
        upd_d      = 1'b0;
        pend_inc_d = pend_inc_q | inc_edge;
        pend_dec_d = pend_dec_q | dec_edge;
        case (state_q)
            IDLE: if (eof && !pause) state_d = CALC;
            // The new position lands on entry to COMMIT, so the COMMIT cycle shows it with its pulses.
            CALC: begin
                x_d     = xs[9:0];
                dx_d    = xs[10];
                bx_d    = xs[11];
                y_d     = ys[9:0];
                dy_d    = ys[10];
                by_d    = ys[11];
                upd_d   = 1'b1;
                state_d = COMMIT;
            end
            COMMIT: begin
                if (pend_inc_q && !pend_dec_q && speed_q < 5'(SPEED_MAX)) speed_d = speed_q + 5'd1;
                if (pend_dec_q && !pend_inc_q && speed_q != 5'd0)         speed_d = speed_q - 5'd1;
                pend_inc_d = inc_edge;
                pend_dec_d = dec_edge;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= 10'(X_INIT);
            y_q        <= 10'(Y_INIT);
            speed_q    <= 5'(SPEED_INIT);
            dx_q       <= 1'b0;
            dy_q       <= 1'b0;
            bx_q       <= 1'b0;
            by_q       <= 1'b0;
            upd_q      <= 1'b0;
            pend_inc_q <= 1'b0;
            pend_dec_q <= 1'b0;
            eof_raw_q  <= 1'b0;
            eof_prev_q <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            speed_q    <= speed_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            upd_q      <= upd_d;
            pend_inc_q <= pend_inc_d;
            pend_dec_q <= pend_dec_d;
            eof_raw_q  <= eof_raw;
            eof_prev_q <= eof_raw_q;
            inc_q      <= inc_vel;
            dec_q      <= dec_vel;
        end
    end

    assign x_ball   = x_q;
    assign y_ball   = y_q;
    assign speed    = speed_q;
    assign dx       = dx_q;
    assign dy       = dy_q;
    assign bounce_x = bx_q;
    assign bounce_y = by_q;
    assign upd_done = upd_q;

endmodule

// File: tb/tb_pxs_ball_motion_ctrl.sv
// Self-checking bench for pxs_ball_motion_ctrl: frames driven as short pixel bursts,
// compared against a per-frame arithmetic model of position, direction and speed.
module tb_pxs_ball_motion_ctrl;

    logic        px_clk = 0;
    logic        reset;
    logic [25:0] RGBStr_i;
    logic        inc_vel, dec_vel, pause;
    logic [9:0]  x_ball, y_ball;
    logic [4:0]  speed;
    logic        dx, dy, bounce_x, bounce_y, upd_done;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int mx, my, msp;
    bit mdx, mdy, pinc, pdec;

    pxs_ball_motion_ctrl dut (
        .px_clk(px_clk), .reset(reset), .RGBStr_i(RGBStr_i),
        .inc_vel(inc_vel), .dec_vel(dec_vel), .pause(pause),
        .x_ball(x_ball), .y_ball(y_ball), .speed(speed), .dx(dx), .dy(dy),
        .bounce_x(bounce_x), .bounce_y(bounce_y), .upd_done(upd_done)
    );

    always #5 px_clk = ~px_clk;

    function automatic logic [25:0] px(input int xc, input int yc);
        logic [5:0] rgb;
        rgb = 6'($urandom);
        return {10'(xc), 10'(yc), rgb};
    endfunction

    function automatic logic [25:0] idle_px();
        return px($urandom_range(0, 639), $urandom_range(0, 478));
    endfunction

    task automatic model_reset();
        mx = 156; my = 232; msp = 1; mdx = 0; mdy = 0; pinc = 0; pdec = 0;
    endtask

    task automatic axis(inout int p, inout bit d, input int maxp, output bit b);
        b = 0;
        if (msp == 0) return;
        if (!d) begin
            if (p + msp >= maxp) begin p = maxp; d = 1; b = 1; end
            else p = p + msp;
        end else begin
            if (p <= msp) begin p = 0; d = 0; b = 1; end
            else p = p - msp;
        end
    endtask

    task automatic check_state(input string tag);
        vectors++;
        if (x_ball !== 10'(mx) || y_ball !== 10'(my) || dx !== mdx || dy !== mdy || speed !== 5'(msp)) begin
            miscompares++;
            $display("FAIL %s state got x=%0d y=%0d dx=%0d dy=%0d spd=%0d exp x=%0d y=%0d dx=%0d dy=%0d spd=%0d",
                     tag, x_ball, y_ball, dx, dy, speed, mx, my, mdx, mdy, msp);
        end
    endtask

    // One frame: optional speed pulses, eof pixel held 'hold' cycles, then watch the update.
    task automatic run_frame(input string tag, input bit pz, input bit inc, input bit dec,
                             input int hold, input bit late_inc);
        int  upd_at, nupd, nbx, nby;
        bit  ebx, eby, bx_at, by_at;
        pause = pz;
        if (inc || dec) begin
            inc_vel = inc; dec_vel = dec;
            @(negedge px_clk);
            inc_vel = 0; dec_vel = 0;
            @(negedge px_clk);
            if (inc) pinc = 1;
            if (dec) pdec = 1;
        end
        ebx = 0; eby = 0;
        if (!pz) begin
            axis(mx, mdx, 624, ebx);
            axis(my, mdy, 464, eby);
        end
        upd_at = -1; nupd = 0; nbx = 0; nby = 0; bx_at = 0; by_at = 0;
        RGBStr_i = px(639, 479);
        for (int k = 1; k <= hold + 6; k++) begin
            @(negedge px_clk);
            if (k == hold) RGBStr_i = idle_px();
            if (upd_done) begin nupd++; upd_at = k; bx_at = bounce_x; by_at = bounce_y; end
            if (bounce_x) nbx++;
            if (bounce_y) nby++;
            if (late_inc && k == 3) inc_vel = 1;
            if (late_inc && k == 4) inc_vel = 0;
        end
        if (!pz) begin
            if (pinc && !pdec) msp = (msp + 1 > 20) ? 20 : msp + 1;
            if (pdec && !pinc) msp = (msp == 0) ? 0 : msp - 1;
            pinc = 0; pdec = 0;
        end
        if (late_inc) pinc = 1;
        vectors++;
        if (nupd !== (pz ? 0 : 1) || (!pz && upd_at !== 3)) begin
            miscompares++;
            $display("FAIL %s upd_done got count=%0d at=%0d exp count=%0d at=3", tag, nupd, upd_at, pz ? 0 : 1);
        end
        vectors++;
        if (nbx !== int'(ebx) || nby !== int'(eby) || bx_at !== ebx || by_at !== eby) begin
            miscompares++;
            $display("FAIL %s bounce got bx=%0d by=%0d (with upd %0d/%0d) exp bx=%0d by=%0d",
                     tag, nbx, nby, bx_at, by_at, ebx, eby);
        end
        check_state(tag);
    endtask

    task automatic do_reset();
        reset = 1; inc_vel = 0; dec_vel = 0; pause = 0; RGBStr_i = idle_px();
        repeat (2) @(negedge px_clk);
        reset = 0;
        model_reset();
        @(negedge px_clk);
    endtask

    task automatic test_reset();
        do_reset();
        check_state("reset");
        vectors++;
        if (upd_done !== 0 || bounce_x !== 0 || bounce_y !== 0) begin
            miscompares++;
            $display("FAIL reset_pulses got %b%b%b exp 000", upd_done, bounce_x, bounce_y);
        end
    endtask

    task automatic test_motion();
        for (int i = 0; i < 3; i++) run_frame("motion", 0, 0, 0, 1, 0);
        vectors++;
        if (x_ball !== 10'd159 || y_ball !== 10'd235) begin
            miscompares++;
            $display("FAIL motion_abs got (%0d,%0d) exp (159,235)", x_ball, y_ball);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 25; i++) run_frame("sat_inc", 0, 1, 0, 1, 0);
        vectors++;
        if (speed !== 5'd20) begin miscompares++; $display("FAIL sat_max got %0d exp 20", speed); end
        for (int i = 0; i < 25; i++) run_frame("sat_dec", 0, 0, 1, 1, 0);
        vectors++;
        if (speed !== 5'd0) begin miscompares++; $display("FAIL sat_min got %0d exp 0", speed); end
        for (int i = 0; i < 2; i++) run_frame("speed0", 0, 0, 0, 1, 0);
    endtask

    task automatic test_both_and_pause();
        for (int i = 0; i < 7; i++) run_frame("to7", 0, 1, 0, 1, 0);
        run_frame("to7", 0, 0, 0, 1, 0);
        run_frame("both", 0, 1, 1, 1, 0);
        vectors++;
        if (speed !== 5'd7) begin miscompares++; $display("FAIL both_edges got %0d exp 7", speed); end
        run_frame("pause", 1, 1, 0, 1, 0);
        run_frame("pause", 1, 0, 0, 1, 0);
        run_frame("resume", 0, 0, 0, 1, 0);
    endtask

    task automatic test_stall_and_late_edge();
        run_frame("stall", 0, 0, 0, 10, 0);
        run_frame("late_inc", 0, 0, 0, 1, 1);
        run_frame("late_apply", 0, 0, 0, 1, 0);
    endtask

    task automatic test_reset_mid();
        int nupd;
        RGBStr_i = px(639, 479);
        @(negedge px_clk);
        RGBStr_i = idle_px();
        @(negedge px_clk);
        reset = 1;
        #1;
        model_reset();
        check_state("reset_mid");
        nupd = 0;
        repeat (2) @(negedge px_clk);
        reset = 0;
        repeat (5) begin @(negedge px_clk); if (upd_done || bounce_x || bounce_y) nupd++; end
        vectors++;
        if (nupd !== 0) begin miscompares++; $display("FAIL reset_mid_pulse got %0d exp 0", nupd); end
        check_state("reset_mid_after");
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++) begin
            bit pz, inc, dec;
            pz  = ($urandom_range(0, 7) == 0);
            inc = ($urandom_range(0, 2) == 0);
            dec = ($urandom_range(0, 4) == 0);
            run_frame("random", pz, inc, dec, $urandom_range(1, 3), 0);
        end
    endtask

    initial begin
        test_reset();
        test_motion();
        test_saturation();
        test_both_and_pause();
        test_stall_and_late_edge();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pxs_ball_motion_ctrl.md
Name: pxs_ball_motion_ctrl

Overview:
Per-frame motion controller for the bouncing-ball overlay. It watches the pixel stream for end-of-frame and advances the ball position once per frame. It handles bounces against the visible-area borders, applies user speed up/down requests, and supports pause. Its x_ball/y_ball/speed outputs drive the ball-drawing overlay stage. Its bounce pulses feed the sound/score logic.

Parameters:
SIZE_BALL, 16, ball side in pixels
VISIBLECOLS, 640, visible columns
VISIBLEROWS, 480, visible rows
SPEED_INIT, 1, speed after reset (pixels/frame)
SPEED_MAX, 20, upper saturation for speed (must be <= 31)
X_INIT, 156, x_ball after reset ((640-16)/4)
Y_INIT, 232, y_ball after reset ((480-16)/2)

Ports:
px_clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
RGBStr_i  in  26  pixel stream; only the `XC and `YC fields from Pxs.vh are used
inc_vel  in  1  speed-up request, level; the rising edge counts
dec_vel  in  1  speed-down request, level; the rising edge counts
pause  in  1  1 = freeze motion
x_ball  out  10  ball left column
y_ball  out  10  ball top row
speed  out  5  current speed
dx  out  1  0 = moving right, 1 = moving left
dy  out  1  0 = moving down, 1 = moving up
bounce_x  out  1  1-cycle pulse on vertical-border bounce
bounce_y  out  1  1-cycle pulse on horizontal-border bounce
upd_done  out  1  1-cycle pulse when a new position is committed

Behaviour:
- Reset (async, any state): x_ball=X_INIT, y_ball=Y_INIT, speed=SPEED_INIT, dx=0, dy=0, pending flags cleared, FSM=IDLE. All pulses and edge-detect registers are 0.
- XMAX = VISIBLECOLS-SIZE_BALL (624). YMAX = VISIBLEROWS-SIZE_BALL (464). Minimum position is 0.
- eof_raw = (`XC==VISIBLECOLS-1 && `YC==VISIBLEROWS-1).
- eof = rising edge of registered eof_raw, so a stalled stream holding the last pixel fires only once.
- inc_vel/dec_vel are edge-detected. A rising edge sets pend_inc or pend_dec. Flags persist until consumed in COMMIT.
- FSM states IDLE, CALC, COMMIT:
  - IDLE: on eof && !pause, go to CALC. If eof arrives with pause=1, the frame is skipped and pending flags are kept.
  - CALC (1 cycle): compute nx and ny in 11-bit arithmetic.
    - dx=0: if x_ball+speed >= XMAX then nx=XMAX, ndx=1, set bounce_x flag; else nx=x_ball+speed.
    - dx=1: if x_ball <= speed then nx=0, ndx=0, set bounce_x flag; else nx=x_ball-speed.
    - Y identical, using YMAX, dy and bounce_y.
    - speed=0: nx=x_ball, ny=y_ball, no bounce.
    - Go to COMMIT.
  - COMMIT (1 cycle): register nx/ny/ndx/ndy to the outputs. Pulse upd_done and any set bounce_x/bounce_y. Then update speed:
    - pend_inc only: speed+1, saturating at SPEED_MAX.
    - pend_dec only: speed-1, saturating at 0.
    - both pending: no change.
    - Clear both flags. A new edge arriving in this same cycle is retained for the next frame.
    - Go to IDLE.
- Latency: outputs change exactly 2 clocks after the cycle in which eof asserts. The new speed applies from the next frame.
- Outputs are stable for the whole visible frame. The drawing stage never sees a mid-frame change.
- A corner hit asserts bounce_x and bounce_y in the same cycle.
- eof arriving while in CALC or COMMIT is ignored. This cannot occur for a legal frame length, but the block stays safe if it does.
- Reset asserted mid-update aborts the update. No pulses are emitted.

Test Plan:
- Reset, then 3 frames, speed=1, dx=dy=0 -> (x,y) goes (156,232), (157,233), (158,234), (159,235); upd_done 3 pulses, each 2 clks after eof; no bounce pulses.
- Preload x=622, dx=0, speed=4, one frame -> x=624, dx=1, bounce_x=1 for 1 clk; next frame x=620.
- Preload x=3, y=2, dx=dy=1, speed=5 -> x=0, y=0, dx=dy=0, bounce_x and bounce_y pulse in the same cycle.
- Pulse inc_vel 25 times, one per frame, from speed=1 -> speed saturates at 20. Then dec_vel 25 times -> speed 0, and position stays constant with no bounces.
- inc_vel and dec_vel rising in the same frame at speed=7 -> speed stays 7. Hold pause=1 over 2 eofs -> no upd_done, position frozen. Release -> motion resumes.
- Hold stream at (639,479) for 10 clks -> exactly one update. Assert reset between eof and COMMIT -> outputs at init values, no upd_done pulse.
